// File: rtl/muldiv_unit_if.sv
// Request/response bundle between control/register file and the HI/LO multiply-divide unit.
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; the result is formed at start and released after a fixed latency.
// Optional MADD/MADDU accumulate ops are enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [63:0]        r_res;

  logic signed [63:0] w_a_sx;
  logic signed [63:0] w_b_sx;
  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic [63:0]        w_result;
  logic               w_launch;
  logic               w_is_div;

  // Returns {remainder, quotient}; covers the divide-by-zero and most-negative/-1 corners explicitly.
  function automatic logic [63:0] div_signed(input logic [31:0] n, input logic [31:0] d);
    logic signed [31:0] sn;
    logic signed [31:0] sd;
    logic signed [31:0] q;
    logic signed [31:0] r;
    sn = $signed(n);
    sd = $signed(d);
    if (d == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = sn;
    end else if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = sn / sd;
      r = sn % sd;
    end
    div_signed = {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] n, input logic [31:0] d);
    if (d == 32'h0) div_unsigned = {n, 32'hFFFF_FFFF};
    else            div_unsigned = {n % d, n / d};
  endfunction

  assign w_a_sx   = {{32{bus.a[31]}}, bus.a};
  assign w_b_sx   = {{32{bus.b[31]}}, bus.b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'h0, bus.a} * {32'h0, bus.b};

  always_comb begin
    w_result = 64'h0;
    w_launch = 1'b0;
    w_is_div = 1'b0;
    case (bus.op)
      OP_MULT:  begin w_result = w_prod_s; w_launch = 1'b1; end
      OP_MULTU: begin w_result = w_prod_u; w_launch = 1'b1; end
      OP_DIV:   begin w_result = div_signed(bus.a, bus.b);   w_launch = 1'b1; w_is_div = 1'b1; end
      OP_DIVU:  begin w_result = div_unsigned(bus.a, bus.b); w_launch = 1'b1; w_is_div = 1'b1; end
`ifdef MULDIV_MADD_EN
      OP_MADD:  begin w_result = {r_hi, r_lo} + w_prod_s; w_launch = 1'b1; end
      OP_MADDU: begin w_result = {r_hi, r_lo} + w_prod_u; w_launch = 1'b1; end
`else
      OP_MADD, OP_MADDU: w_launch = 1'b0;
`endif
      default:  w_launch = 1'b0;
    endcase
  end

  // Result hold register: captured once at launch, released when the counter expires.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && bus.start && w_launch) r_res <= w_result;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= 32'h0;
      r_lo    <= 32'h0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (w_launch) begin
              r_cnt   <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
              r_busy  <= 1'b1;
              r_state <= RUN;
            end else if (bus.op == OP_MTHI) begin
              r_hi <= bus.a;
            end else if (bus.op == OP_MTLO) begin
              r_lo <= bus.a;
            end
          end
        end
        RUN: begin
          if (r_cnt == CNT_W'(1)) begin
            r_hi    <= r_res[63:32];
            r_lo    <= r_res[31:0];
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
